// File: rtl/axis_dense_layer_if.sv
// AXI-Stream bundle (tdata/tvalid/tready/tlast) shared by the slave and master ports of the dense layer.
// Ports: master drives tdata/tvalid/tlast and samples tready; slave is the mirror image.
// No logic here; parameterised on stream width only.
interface axis_dense_layer_if #(
  parameter int AXIS_W = 64
) ();
  logic [AXIS_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_dense_layer.sv
// Fully-connected layer y = sat(W*x + b) over AXI-Stream, Q(DATA_W-FRAC_W).FRAC_W fixed point, one MAC per cycle.
// Latency: BEATS load beats, then N_OUT*(N_IN+1) compute cycles, then ceil(N_OUT/LANES) result beats.
// Backpressure: slave tready only while loading; master beat held stable until tready; no load/send overlap.
// Ports: aclk, aresetn (async active-low); s_axis (slave stream in: x, W row-major, b);
//   m_axis (master stream out, packed results, tlast on final beat); busy (COMPUTE/SEND);
//   frame_err (one-cycle pulse on frame length / tlast mismatch).
// Build option: define DENSE_RELU_EN to clamp negative results to zero after saturation.
module axis_dense_layer #(
  parameter int N_IN   = 9,
  parameter int N_OUT  = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int AXIS_W = 64
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axis_dense_layer_if.slave    s_axis,
  axis_dense_layer_if.master   m_axis,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int LANES  = AXIS_W / DATA_W;
  localparam int TOTAL  = N_IN + N_IN * N_OUT + N_OUT;
  localparam int OBEATS = (N_OUT + LANES - 1) / LANES;
  localparam int IDX_W  = $clog2(TOTAL + LANES + 1);
  localparam int MEM_D  = 1 << IDX_W;
  localparam int SW     = $clog2(N_IN + 1);
  localparam int OW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int SBW    = (OBEATS > 1) ? $clog2(OBEATS) : 1;
  localparam int ACC_W  = 2 * DATA_W + $clog2(N_IN) + 1;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_SEND    = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // Register file holding x, W and b in frame order; entries at and beyond TOTAL are never written.
  logic signed [DATA_W-1:0] r_mem [MEM_D];

  logic [IDX_W-1:0]          r_wcnt;
  logic                      r_s_rdy;
  logic                      r_ferr;
  logic [SW-1:0]             r_i;
  logic [OW-1:0]             r_o;
  logic [IDX_W-1:0]          r_xptr;
  logic [IDX_W-1:0]          r_wptr;
  logic [IDX_W-1:0]          r_bptr;
  logic signed [ACC_W-1:0]   r_acc;
  logic [SBW-1:0]            r_sbeat;
  // Packed result buffer; lanes past N_OUT stay zero from reset so pad lanes go out as 0.
  logic [OBEATS*AXIS_W-1:0]  r_obuf;

  logic                      w_accept;
  logic                      w_last_beat;
  logic                      w_mac_last;
  logic                      w_o_last;
  logic                      w_send_hs;
  logic                      w_sbeat_last;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_acc_nxt;
  logic signed [ACC_W-1:0]   w_sh;
  logic signed [ACC_W-1:0]   w_bias_acc;
  logic signed [DATA_W-1:0]  w_sat;
  logic signed [DATA_W-1:0]  w_res;

  // r_s_rdy is only ever high in LOAD, so it alone qualifies the slave handshake.
  assign w_accept     = s_axis.tvalid && r_s_rdy;
  assign w_last_beat  = (r_wcnt + IDX_W'(LANES)) >= IDX_W'(TOTAL);
  assign w_mac_last   = (r_i == SW'(N_IN));
  assign w_o_last     = (r_o == OW'(N_OUT - 1));
  assign w_send_hs    = (r_state == ST_SEND) && m_axis.tready;
  assign w_sbeat_last = (r_sbeat == SBW'(OBEATS - 1));

  // Datapath: full-width signed product; the final MAC of a neuron feeds the result straight
  // from the adder so no extra drain cycle is needed.
  assign w_prod     = r_mem[r_wptr] * r_mem[r_xptr];
  assign w_acc_nxt  = r_acc + ACC_W'(w_prod);
  assign w_sh       = w_acc_nxt >>> FRAC_W;
  assign w_bias_acc = ACC_W'(r_mem[r_bptr]) <<< FRAC_W;

  always_comb begin
    w_sat = w_sh[DATA_W-1:0];
    if (w_sh > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_W-1:0];
    end else if (w_sh < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_W-1:0];
    end
  end

`ifdef DENSE_RELU_EN
  assign w_res = w_sat[DATA_W-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and stream outputs.
  always_comb begin
    w_state_nxt   = r_state;
    busy          = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    m_axis.tdata  = '0;
    unique case (r_state)
      ST_LOAD: begin
        if (w_accept && w_last_beat) w_state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        busy = 1'b1;
        if (w_mac_last && w_o_last) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        busy          = 1'b1;
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = w_sbeat_last;
        m_axis.tdata  = r_obuf[r_sbeat*AXIS_W +: AXIS_W];
        if (w_send_hs && w_sbeat_last) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  assign s_axis.tready = r_s_rdy;
  assign frame_err     = r_ferr;

  // Register file writes: lane 0 lands at the current word count, pad lanes are dropped.
  always_ff @(posedge aclk) begin
    if (w_accept) begin
      for (int k = 0; k < LANES; k++) begin
        if ((r_wcnt + IDX_W'(k)) < IDX_W'(TOTAL)) begin
          r_mem[r_wcnt + IDX_W'(k)] <= s_axis.tdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Control counters, accumulator and result buffer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wcnt  <= '0;
      r_s_rdy <= 1'b0;
      r_ferr  <= 1'b0;
      r_i     <= '0;
      r_o     <= '0;
      r_xptr  <= '0;
      r_wptr  <= '0;
      r_bptr  <= '0;
      r_acc   <= '0;
      r_sbeat <= '0;
      r_obuf  <= '0;
    end else begin
      // Ready tracks the state we are about to be in, so it rises one edge after reset
      // and one edge after the last result beat, and drops right after the last load beat.
      r_s_rdy <= (w_state_nxt == ST_LOAD);
      r_ferr  <= 1'b0;
      unique case (r_state)
        ST_LOAD: begin
          r_i     <= '0;
          r_o     <= '0;
          r_xptr  <= '0;
          r_wptr  <= IDX_W'(N_IN);
          r_bptr  <= IDX_W'(N_IN + N_IN * N_OUT);
          r_acc   <= '0;
          r_sbeat <= '0;
          if (w_accept) begin
            // Word count decides frame end; a tlast that disagrees flags an error.
            // Early tlast throws the partial frame away, a missing tlast does not.
            r_ferr <= (s_axis.tlast != w_last_beat);
            if (w_last_beat || s_axis.tlast) begin
              r_wcnt <= '0;
            end else begin
              r_wcnt <= r_wcnt + IDX_W'(LANES);
            end
          end
        end
        ST_COMPUTE: begin
          if (r_i == '0) begin
            r_acc  <= w_bias_acc;
            r_xptr <= '0;
            r_i    <= r_i + 1'b1;
          end else begin
            r_acc  <= w_acc_nxt;
            r_xptr <= r_xptr + 1'b1;
            r_wptr <= r_wptr + 1'b1;
            if (w_mac_last) begin
              r_obuf[r_o*DATA_W +: DATA_W] <= w_res;
              r_i    <= '0;
              r_o    <= r_o + 1'b1;
              r_bptr <= r_bptr + 1'b1;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (w_send_hs) r_sbeat <= r_sbeat + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_dense_layer.sv
module tb_axis_dense_layer;

  localparam int N_IN   = 9;
  localparam int N_OUT  = 4;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int AXIS_W = 64;
  localparam int LANES  = AXIS_W / DATA_W;
  localparam int TOTAL  = N_IN + N_IN * N_OUT + N_OUT;
  localparam int BEATS  = (TOTAL + LANES - 1) / LANES;
  localparam int OBEATS = (N_OUT + LANES - 1) / LANES;
  localparam longint QMAX = (longint'(1) <<< (DATA_W - 1)) - 1;
  localparam longint QMIN = -(longint'(1) <<< (DATA_W - 1));

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic busy;
  logic frame_err;

  axis_dense_layer_if #(.AXIS_W(AXIS_W)) s_if ();
  axis_dense_layer_if #(.AXIS_W(AXIS_W)) m_if ();

  always #5 aclk = ~aclk;

  axis_dense_layer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .AXIS_W(AXIS_W)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axis(s_if.slave),
    .m_axis(m_if.master),
    .busy(busy),
    .frame_err(frame_err)
  );

  typedef struct packed {
    logic [AXIS_W-1:0] d;
    logic              l;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int ferr_seen = 0;
  int ferr_exp = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

  int fx [N_IN];
  int fw [N_OUT][N_IN];
  int fb [N_OUT];

  // Reference: real-valued fixed-point math on wide integers, floor shift, clamp, optional ReLU.
  function automatic longint neuron_ref(input int o);
    longint acc;
    longint r;
    acc = longint'(fb[o]) * (longint'(1) <<< FRAC_W);
    for (int i = 0; i < N_IN; i++) acc += longint'(fx[i]) * longint'(fw[o][i]);
    r = acc >>> FRAC_W;
    if (r > QMAX) r = QMAX;
    if (r < QMIN) r = QMIN;
`ifdef DENSE_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  function automatic void push_expected();
    beat_t b;
    longint r;
    for (int ob = 0; ob < OBEATS; ob++) begin
      b.d = '0;
      for (int k = 0; k < LANES; k++) begin
        if (ob * LANES + k < N_OUT) begin
          r = neuron_ref(ob * LANES + k);
          b.d[k*DATA_W +: DATA_W] = DATA_W'(r);
        end
      end
      b.l = (ob == OBEATS - 1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic void set_uniform(input int xv, input int wv, input int bv);
    for (int i = 0; i < N_IN; i++) fx[i] = xv;
    for (int o = 0; o < N_OUT; o++) begin
      fb[o] = bv;
      for (int i = 0; i < N_IN; i++) fw[o][i] = wv;
    end
  endfunction

  function automatic int rnd_word();
    logic signed [DATA_W-1:0] t;
    if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 1024)) - 512;
    t = DATA_W'($urandom);
    return int'(t);
  endfunction

  function automatic void set_random();
    for (int i = 0; i < N_IN; i++) fx[i] = rnd_word();
    for (int o = 0; o < N_OUT; o++) begin
      fb[o] = rnd_word();
      for (int i = 0; i < N_IN; i++) fw[o][i] = rnd_word();
    end
  endfunction

  task automatic fail_timeout(input string what);
    n_cmp++;
    n_err++;
    $display("FAIL timeout %s: waited too long, required the event within budget", what);
  endtask

  // Tasks start and end just after a rising edge. last_at: beat carrying tlast (0 = none).
  task automatic send_frame(input int last_at);
    logic [DATA_W-1:0] words [TOTAL];
    int nb;
    int n;
    int idx;
    for (int i = 0; i < N_IN; i++) words[i] = DATA_W'(fx[i]);
    for (int o = 0; o < N_OUT; o++)
      for (int i = 0; i < N_IN; i++) words[N_IN + o*N_IN + i] = DATA_W'(fw[o][i]);
    for (int o = 0; o < N_OUT; o++) words[N_IN + N_IN*N_OUT + o] = DATA_W'(fb[o]);
    nb = (last_at > 0 && last_at < BEATS) ? last_at : BEATS;
    for (int b = 0; b < nb; b++) begin
      s_if.tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge aclk);
        #1;
      end
      s_if.tvalid = 1'b1;
      for (int k = 0; k < LANES; k++) begin
        idx = b * LANES + k;
        s_if.tdata[k*DATA_W +: DATA_W] = (idx < TOTAL) ? words[idx] : DATA_W'($urandom);
      end
      s_if.tlast = (b + 1 == last_at);
      n = 0;
      @(negedge aclk);
      while (!s_if.tready && n < 300) begin
        @(negedge aclk);
        n++;
      end
      if (n >= 300) fail_timeout("s_axis_tready");
      @(posedge aclk);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge aclk);
    while (!(exp_q.size() == 0 && !busy && s_if.tready) && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 3000) fail_timeout("idle");
    @(posedge aclk);
    #1;
  endtask

  task automatic check_val(input string what, input logic [AXIS_W-1:0] act, input logic [AXIS_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", what, act, req);
    end
  endtask

  // m_axis_tready driver.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = 1'($urandom_range(0, 1));
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  // Monitor: samples on the falling edge, pops on handshake.
  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        n_cmp++;
        if ({m_if.tvalid, m_if.tlast, m_if.tdata, s_if.tready, busy, frame_err} !== '0) begin
          n_err++;
          $display("FAIL reset_outputs: tvalid=%b tlast=%b tdata=%h tready=%b busy=%b ferr=%b, required all 0",
                   m_if.tvalid, m_if.tlast, m_if.tdata, s_if.tready, busy, frame_err);
        end
      end else begin
        if (frame_err === 1'b1) ferr_seen++;
        if (busy === 1'b1) begin
          n_cmp++;
          if (s_if.tready !== 1'b0) begin
            n_err++;
            $display("FAIL tready_while_busy: got %b, required 0", s_if.tready);
          end
        end
        if (m_if.tvalid === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat: got tdata=%h tlast=%b, required no beat", m_if.tdata, m_if.tlast);
          end else begin
            if (m_if.tdata !== exp_q[0].d || m_if.tlast !== exp_q[0].l) begin
              n_err++;
              $display("FAIL result_beat: got tdata=%h tlast=%b, required tdata=%h tlast=%b",
                       m_if.tdata, m_if.tlast, exp_q[0].d, exp_q[0].l);
            end
            if (m_if.tready === 1'b1) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    aresetn     = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check_val("tready_before_first_edge", AXIS_W'(s_if.tready), AXIS_W'(0));
    @(posedge aclk);
    @(negedge aclk);
    check_val("tready_after_first_edge", AXIS_W'(s_if.tready), AXIS_W'(1));
    @(posedge aclk);
    #1;

    // 1: unit weights
    set_uniform(256, 256, 0);
    push_expected();
    send_frame(BEATS);
    wait_idle();

    // 2: positive and negative saturation
    set_uniform(32767, 32767, 32767);
    push_expected();
    send_frame(BEATS);
    wait_idle();
    set_uniform(32767, -32768, 0);
    push_expected();
    send_frame(BEATS);
    wait_idle();

    // 3: negative result (ReLU-dependent)
    set_uniform(256, -256, 0);
    push_expected();
    send_frame(BEATS);
    wait_idle();

    // 4: stalled output beat
    set_uniform(256, 256, 0);
    rdy_mode = 2;
    push_expected();
    send_frame(BEATS);
    n = 0;
    @(negedge aclk);
    while (m_if.tvalid !== 1'b1 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 500) fail_timeout("m_axis_tvalid");
    repeat (5) @(posedge aclk);
    #1;
    rdy_mode = 0;
    wait_idle();

    // 5: early tlast -> discarded frame, then a good frame
    set_uniform(256, 256, 0);
    send_frame(5);
    ferr_exp++;
    repeat (80) @(posedge aclk);
    #1;
    check_val("tready_after_early_tlast", AXIS_W'(s_if.tready), AXIS_W'(1));
    check_val("ferr_after_early_tlast", AXIS_W'(ferr_seen), AXIS_W'(ferr_exp));
    push_expected();
    send_frame(BEATS);
    wait_idle();

    // missing tlast on the final beat: frame still used, error flagged
    set_random();
    push_expected();
    send_frame(0);
    ferr_exp++;
    wait_idle();

    // 6: reset during COMPUTE, then recovery
    set_uniform(256, 256, 0);
    push_expected();
    send_frame(BEATS);
    n = 0;
    @(negedge aclk);
    while (busy !== 1'b1 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) fail_timeout("busy");
    repeat (4) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    push_expected();
    send_frame(BEATS);
    wait_idle();

    // random frames with random output backpressure
    rdy_mode = 1;
    for (int f = 0; f < 25; f++) begin
      set_random();
      push_expected();
      send_frame(BEATS);
      if (f % 3 == 0) wait_idle();
    end
    wait_idle();
    rdy_mode = 0;

    check_val("frame_err_pulses", AXIS_W'(ferr_seen), AXIS_W'(ferr_exp));
    check_val("scoreboard_drained", AXIS_W'(exp_q.size()), AXIS_W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
